score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter GOAL_HOLD_CYCLES, default 25000000, dead-ball cycles after a goal (>=1).
REQ-002 Parameter WIN_SCORE, default 10, decimal score that ends the match early (1..99).
REQ-003 clk  input  1  system clock; the block has one clock.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 team1_score  input  1  goal level from ball controller; may stay high for many cycles.
REQ-006 team2_score  input  1  same as REQ-005, for team 2.
REQ-007 time_left  input  8  match seconds remaining, from game controller.
REQ-008 new_game  input  1  single-cycle request to clear scores and re-arm.
REQ-009 team1_tens, team1_ones  output  4 each  team 1 score, BCD.
REQ-010 team2_tens, team2_ones  output  4 each  team 2 score, BCD.
REQ-011 goal_flash  output  1  high during the dead-ball hold.
REQ-012 last_scorer  output  2  00 none, 01 team 1, 10 team 2, 11 both in the same cycle.
REQ-013 match_end  output  1  high while in FINISHED; it drives the game controller's game_over.
REQ-014 winner  output  2  00 undecided, 01 team 1, 10 team 2, 11 draw; valid only while match_end=1.

Function
REQ-015 The block SHALL register team1_score and team2_score once and count a goal only on a 0->1 edge of the registered value.
- Result: exactly 1 cycle of latency from the input edge to the score update.
REQ-016 FSM states SHALL be IDLE, PLAYING, GOAL_HOLD and FINISHED.
REQ-017 IDLE->PLAYING SHALL occur when time_left!=0.
REQ-018 PLAYING, on one or two goal edges:
- increment each scoring team's score by 1;
- update last_scorer;
- load the hold counter with GOAL_HOLD_CYCLES-1;
- go to GOAL_HOLD.
REQ-019 In GOAL_HOLD, goal edges SHALL be ignored; the state SHALL return to PLAYING on the cycle after the counter reaches 0.
REQ-020 PLAYING or GOAL_HOLD -> FINISHED SHALL occur when time_left==0 or either score equals WIN_SCORE.
- Precedence: this test is evaluated after the REQ-018 update of the same cycle.
- Result: a goal that arrives in the same cycle as time_left reaching 0 still counts.
REQ-021 BCD increment:
- ones 9 -> 0 with tens +1;
- 99 saturates at 99, and further edges are dropped.
REQ-022 Entering FINISHED, winner SHALL be set as follows, comparing tens first and then ones:
- 01 if team 1 is greater;
- 10 if team 2 is greater;
- 11 if equal.
In FINISHED, the registered winner SHALL stay fixed.
REQ-023 new_game in any state SHALL be handled as follows:
- clear all scores and last_scorer;
- set winner to 00;
- clear goal_flash and the hold counter;
- go to IDLE on the next edge.
new_game SHALL override goal edges in the same cycle.
REQ-024 goal_flash SHALL be 1 exactly while the state is GOAL_HOLD (GOAL_HOLD_CYCLES cycles per goal).
REQ-025 match_end SHALL be 1 exactly while the state is FINISHED.
REQ-026 A score at WIN_SCORE with time_left>0 SHALL reach FINISHED via REQ-020, skipping GOAL_HOLD.

Reset
REQ-027 With rst_n=0 at a clk edge, the block SHALL go to the following values:
- state IDLE;
- all BCD digits 0;
- goal_flash 0, last_scorer 00, match_end 0, winner 00;
- edge registers 0;
- hold counter 0.
REQ-028 Reset mid-hold or mid-match SHALL abandon the match with no residual goal count.
- Exception: an input already high at reset release SHALL be recorded as a goal only after it falls and rises again.

Structure
REQ-029 A shared package SHALL hold:
- the state encoding;
- the winner and last_scorer codes;
- the BCD digit width.
REQ-030 The per-team saturating BCD counter SHALL be one sub-module, bcd_score_counter (inputs clk, rst_n, clr, inc; outputs tens, ones), instantiated twice.
REQ-031 The hold counter width SHALL be $clog2(GOAL_HOLD_CYCLES+1).

Verification (GOAL_HOLD_CYCLES=4, WIN_SCORE=3 in the bench)
REQ-032 time_left=60, team1_score held high for 20 cycles -> team1 = 0/1 one cycle after the edge; goal_flash high for 4 cycles; no second count.
REQ-033 Both scores rise in the same cycle -> both teams 0/1, last_scorer=11, one hold period.
REQ-034 team2 scores 3 goals, each separated by a hold -> match_end=1 immediately after the third goal, winner=10, goal_flash stays 0.
REQ-035 Score 1-1, then time_left=0 in the same cycle as a team1 edge -> team1=2, FINISHED, winner=01; with no edge instead -> winner=11.
REQ-036 Scores preset to 9 through repeated goals (WIN_SCORE overridden to 99), one more goal -> tens=1, ones=0; at 99, a goal -> stays 99.
REQ-037 rst_n=0 during GOAL_HOLD with team1_score high -> all outputs 0 next cycle; after release with the input still high -> no count until it falls and rises again.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared types for the score keeper:
// FSM states, result codes and BCD helpers.
package score_keeper_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef struct packed {
    digit_t tens;
    digit_t ones;
  } bcd2_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAYING,
    ST_GOAL_HOLD,
    ST_FINISHED
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_T1   = 2'b01,
    WIN_T2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  typedef enum logic [1:0] {
    LS_NONE = 2'b00,
    LS_T1   = 2'b01,
    LS_T2   = 2'b10,
    LS_BOTH = 2'b11
  } scorer_e;

  // Two-digit BCD increment, saturating at 99.
  function automatic bcd2_t bcd_inc(bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.tens == digit_t'(9) &&
        v.ones == digit_t'(9)) begin
      r = v;
    end else if (v.ones == digit_t'(9)) begin
      r.ones = '0;
      r.tens = v.tens + digit_t'(1);
    end else begin
      r.ones = v.ones + digit_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// One team's two-digit saturating BCD score.
// clr wins over inc.
module bcd_score_counter
  import score_keeper_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones
);

  bcd2_t cnt_q;
  bcd2_t cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = bcd_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tens = cnt_q.tens;
  assign ones = cnt_q.ones;

endmodule

// File: rtl/score_keeper.sv
// Match score keeper: goal edge detect,
// dead-ball hold and end-of-match decision.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int GOAL_HOLD_CYCLES = 25000000,
  parameter int WIN_SCORE        = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               team1_score,
  input  logic               team2_score,
  input  logic [7:0]         time_left,
  input  logic               new_game,
  output logic [DIGIT_W-1:0] team1_tens,
  output logic [DIGIT_W-1:0] team1_ones,
  output logic [DIGIT_W-1:0] team2_tens,
  output logic [DIGIT_W-1:0] team2_ones,
  output logic               goal_flash,
  output logic [1:0]         last_scorer,
  output logic               match_end,
  output logic [1:0]         winner
);

  localparam int HOLD_W =
    $clog2(GOAL_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    HOLD_W'(GOAL_HOLD_CYCLES - 1);
  localparam bcd2_t WIN_BCD = bcd2_t'({
    digit_t'(WIN_SCORE / 10),
    digit_t'(WIN_SCORE % 10)});

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  winner_e           winner_q, winner_d;
  scorer_e           last_q, last_d;
  logic [1:0]        in_q, in_d;
  logic [1:0]        prev_q, prev_d;
  logic [1:0]        arm_q, arm_d;

  logic [1:0] raw;
  logic [1:0] goal;
  logic       clr;
  logic       inc1;
  logic       inc2;
  logic       live;
  bcd2_t      t1, t2;
  bcd2_t      t1_nx, t2_nx;

  assign raw = {team2_score, team1_score};

  // An input high at reset release must drop
  // once before its next rise can count.
  assign goal = in_q & ~prev_q & arm_q;

  assign t1 = {team1_tens, team1_ones};
  assign t2 = {team2_tens, team2_ones};

  assign live = (state_q == ST_PLAYING) ||
                (state_q == ST_GOAL_HOLD);

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    winner_d = winner_q;
    last_d   = last_q;
    in_d     = raw;
    prev_d   = in_q;
    arm_d    = arm_q | ~raw;
    clr      = 1'b0;
    inc1     = 1'b0;
    inc2     = 1'b0;
    t1_nx    = t1;
    t2_nx    = t2;
    if (new_game) begin
      clr      = 1'b1;
      state_d  = ST_IDLE;
      hold_d   = '0;
      winner_d = WIN_NONE;
      last_d   = LS_NONE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (time_left != '0) begin
            state_d = ST_PLAYING;
          end
        end
        ST_PLAYING: begin
          if (|goal) begin
            inc1    = goal[0];
            inc2    = goal[1];
            last_d  = scorer_e'(goal);
            hold_d  = HOLD_LOAD;
            state_d = ST_GOAL_HOLD;
          end
        end
        ST_GOAL_HOLD: begin
          if (hold_q == '0) begin
            state_d = ST_PLAYING;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
        ST_FINISHED: begin
        end
      endcase
      if (inc1) t1_nx = bcd_inc(t1);
      if (inc2) t2_nx = bcd_inc(t2);
      // End test sees this cycle's goals.
      if (live &&
          (time_left == '0 ||
           t1_nx == WIN_BCD ||
           t2_nx == WIN_BCD)) begin
        state_d = ST_FINISHED;
        if (t1_nx > t2_nx) begin
          winner_d = WIN_T1;
        end else if (t2_nx > t1_nx) begin
          winner_d = WIN_T2;
        end else begin
          winner_d = WIN_DRAW;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      winner_q <= WIN_NONE;
      last_q   <= LS_NONE;
      in_q     <= '0;
      prev_q   <= '0;
      arm_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      in_q     <= in_d;
      prev_q   <= prev_d;
      arm_q    <= arm_d;
    end
  end

  bcd_score_counter u_team1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc1),
    .tens  (team1_tens),
    .ones  (team1_ones)
  );

  bcd_score_counter u_team2 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc2),
    .tens  (team2_tens),
    .ones  (team2_ones)
  );

  assign goal_flash  = (state_q == ST_GOAL_HOLD);
  assign match_end   = (state_q == ST_FINISHED);
  assign winner      = winner_q;
  assign last_scorer = last_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: integer reference model
// feeding a per-cycle scoreboard, plus directed checks.
module tb_score_keeper;

  localparam int G = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_t1, a_t2, a_ng;
  logic [7:0] a_tl;
  logic       b_t1, b_t2, b_ng;
  logic [7:0] b_tl;

  logic [3:0] a_1t, a_1o, a_2t, a_2o;
  logic       a_fl, a_me;
  logic [1:0] a_ls, a_wn;
  logic [3:0] b_1t, b_1o, b_2t, b_2o;
  logic       b_fl, b_me;
  logic [1:0] b_ls, b_wn;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  score_keeper #(
    .GOAL_HOLD_CYCLES (G),
    .WIN_SCORE        (3)
  ) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .team1_score (a_t1),
    .team2_score (a_t2),
    .time_left   (a_tl),
    .new_game    (a_ng),
    .team1_tens  (a_1t),
    .team1_ones  (a_1o),
    .team2_tens  (a_2t),
    .team2_ones  (a_2o),
    .goal_flash  (a_fl),
    .last_scorer (a_ls),
    .match_end   (a_me),
    .winner      (a_wn)
  );

  score_keeper #(
    .GOAL_HOLD_CYCLES (G),
    .WIN_SCORE        (99)
  ) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .team1_score (b_t1),
    .team2_score (b_t2),
    .time_left   (b_tl),
    .new_game    (b_ng),
    .team1_tens  (b_1t),
    .team1_ones  (b_1o),
    .team2_tens  (b_2t),
    .team2_ones  (b_2o),
    .goal_flash  (b_fl),
    .last_scorer (b_ls),
    .match_end   (b_me),
    .winner      (b_wn)
  );

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // Reference model: plain integers, 0 idle,
  // 1 playing, 2 hold, 3 finished.
  typedef struct {
    int st, s1, s2, last, win, hold;
    bit r1, p1, a1, r2, p2, a2;
  } m_t;

  function automatic m_t step(m_t m, bit rn,
      bit i1, bit i2, int tl, bit ng, int w);
    m_t n;
    bit g1, g2;
    n = m;
    if (!rn) begin
      n = '{default: 0};
      return n;
    end
    g1 = m.r1 && !m.p1 && m.a1;
    g2 = m.r2 && !m.p2 && m.a2;
    n.a1 = m.a1 || !i1;
    n.a2 = m.a2 || !i2;
    n.p1 = m.r1;
    n.p2 = m.r2;
    n.r1 = i1;
    n.r2 = i2;
    if (ng) begin
      n.st = 0; n.s1 = 0; n.s2 = 0;
      n.last = 0; n.win = 0; n.hold = 0;
      return n;
    end
    if (m.st == 0 && tl != 0) n.st = 1;
    if (m.st == 1 && (g1 || g2)) begin
      if (g1 && m.s1 < 99) n.s1 = m.s1 + 1;
      if (g2 && m.s2 < 99) n.s2 = m.s2 + 1;
      n.last = (g2 ? 2 : 0) + (g1 ? 1 : 0);
      n.hold = G - 1;
      n.st = 2;
    end
    if (m.st == 2) begin
      if (m.hold == 0) n.st = 1;
      else n.hold = m.hold - 1;
    end
    if ((m.st == 1 || m.st == 2) &&
        (tl == 0 || n.s1 == w || n.s2 == w)) begin
      n.st = 3;
      if (n.s1 > n.s2) n.win = 1;
      else if (n.s2 > n.s1) n.win = 2;
      else n.win = 3;
    end
    return n;
  endfunction

  function automatic logic [21:0] expv(m_t m);
    return {4'(m.s1 / 10), 4'(m.s1 % 10),
            4'(m.s2 / 10), 4'(m.s2 % 10),
            m.st == 2, 2'(m.last),
            m.st == 3, 2'(m.win)};
  endfunction

  typedef struct {
    logic [21:0] a;
    logic [21:0] b;
  } exp_t;

  exp_t sbq[$];
  m_t   ma = '{default: 0};
  m_t   mb = '{default: 0};

  wire [21:0] va = {a_1t, a_1o, a_2t, a_2o,
                    a_fl, a_ls, a_me, a_wn};
  wire [21:0] vb = {b_1t, b_1o, b_2t, b_2o,
                    b_fl, b_ls, b_me, b_wn};

  always @(posedge clk) begin
    exp_t e;
    ma = step(ma, rst_n, a_t1, a_t2,
              int'(a_tl), a_ng, 3);
    mb = step(mb, rst_n, b_t1, b_t2,
              int'(b_tl), b_ng, 99);
    e.a = expv(ma);
    e.b = expv(mb);
    sbq.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("cyc_a", 32'(va), 32'(e.a));
      chk("cyc_b", 32'(vb), 32'(e.b));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic flash_cnt(int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (a_fl) c++;
    end
  endtask

  task automatic new_game_a();
    a_ng = 1'b1;
    cyc(1);
    a_ng = 1'b0;
    cyc(3);
  endtask

  task automatic pulse_a(bit team);
    if (team) a_t2 = 1'b1;
    else a_t1 = 1'b1;
    cyc(2);
    a_t1 = 1'b0;
    a_t2 = 1'b0;
    cyc(6);
  endtask

  initial begin
    int fc, f1;
    rst_n = 1'b0;
    a_t1 = 0; a_t2 = 0; a_ng = 0; a_tl = 0;
    b_t1 = 0; b_t2 = 0; b_ng = 0; b_tl = 0;
    cyc(3);
    chk("rst_a", 32'(va), 32'd0);
    chk("rst_b", 32'(vb), 32'd0);
    rst_n = 1'b1;
    cyc(2);
    a_tl = 8'd60;
    b_tl = 8'd60;
    cyc(2);

    // long-held goal level counts once
    a_t1 = 1'b1;
    flash_cnt(20, fc);
    a_t1 = 1'b0;
    chk("hold_flash", fc, 4);
    chk("hold_t1", {a_1t, a_1o}, 8'h01);
    chk("hold_last", a_ls, 2'b01);
    cyc(2);

    // simultaneous goals
    new_game_a();
    chk("ng_clear", 32'(va), 32'd0);
    a_t1 = 1'b1;
    a_t2 = 1'b1;
    flash_cnt(10, fc);
    a_t1 = 1'b0;
    a_t2 = 1'b0;
    chk("both_flash", fc, 4);
    chk("both_t1", {a_1t, a_1o}, 8'h01);
    chk("both_t2", {a_2t, a_2o}, 8'h01);
    chk("both_last", a_ls, 2'b11);
    cyc(2);

    // win by reaching WIN_SCORE
    new_game_a();
    for (int g = 0; g < 3; g++) begin
      a_t2 = 1'b1;
      flash_cnt(2, f1);
      a_t2 = 1'b0;
      flash_cnt(6, fc);
      chk($sformatf("win_flash%0d", g),
          fc + f1, (g == 2) ? 0 : 4);
    end
    chk("win_end", a_me, 1'b1);
    chk("win_who", a_wn, 2'b10);
    chk("win_t2", {a_2t, a_2o}, 8'h03);

    // goal on the same cycle time runs out
    new_game_a();
    pulse_a(0);
    pulse_a(1);
    a_t1 = 1'b1;
    cyc(1);
    a_tl = 8'd0;
    cyc(3);
    a_t1 = 1'b0;
    chk("tz_t1", {a_1t, a_1o}, 8'h02);
    chk("tz_end", a_me, 1'b1);
    chk("tz_who", a_wn, 2'b01);

    // time out on a draw
    a_tl = 8'd60;
    new_game_a();
    pulse_a(0);
    pulse_a(1);
    a_tl = 8'd0;
    cyc(3);
    chk("draw_end", a_me, 1'b1);
    chk("draw_who", a_wn, 2'b11);
    a_tl = 8'd60;

    // reset mid-hold with input held high
    new_game_a();
    a_t1 = 1'b1;
    cyc(3);
    chk("rh_inhold", a_fl, 1'b1);
    rst_n = 1'b0;
    cyc(1);
    chk("rh_zero", 32'(va), 32'd0);
    rst_n = 1'b1;
    cyc(10);
    chk("rh_nocount", {a_1t, a_1o}, 8'h00);
    a_t1 = 1'b0;
    cyc(3);
    a_t1 = 1'b1;
    cyc(3);
    chk("rh_recount", {a_1t, a_1o}, 8'h01);
    a_t1 = 1'b0;
    cyc(6);

    // BCD carry and saturation on the 99 build
    for (int g = 1; g <= 100; g++) begin
      b_t1 = 1'b1;
      cyc(2);
      b_t1 = 1'b0;
      cyc(6);
      if (g == 9)
        chk("bcd_9", {b_1t, b_1o}, 8'h09);
      if (g == 10)
        chk("bcd_10", {b_1t, b_1o}, 8'h10);
      if (g == 99)
        chk("bcd_99", {b_1t, b_1o}, 8'h99);
      if (g == 100)
        chk("bcd_sat", {b_1t, b_1o}, 8'h99);
    end
    chk("bcd_end", b_me, 1'b1);
    chk("bcd_who", b_wn, 2'b01);

    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end

endmodule
